// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared 800x480 panel timing constants and pixel type
package display_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 48;
    localparam int H_BP     = 88;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 13;
    localparam int V_SYNC   = 3;
    localparam int V_BP     = 32;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous show-ahead FIFO with single-cycle flush
module pixel_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign empty   = (r_count == '0);
    assign full    = (r_count == (AW+1)'(DEPTH));
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/lcd_scanout.sv
// rtl/lcd_scanout.sv - parallel-LCD timing generator fed from a pixel FIFO
module lcd_scanout #(
    parameter int H_ACTIVE   = display_pkg::H_ACTIVE,
    parameter int H_FP       = display_pkg::H_FP,
    parameter int H_SYNC     = display_pkg::H_SYNC,
    parameter int H_BP       = display_pkg::H_BP,
    parameter int V_ACTIVE   = display_pkg::V_ACTIVE,
    parameter int V_FP       = display_pkg::V_FP,
    parameter int V_SYNC     = display_pkg::V_SYNC,
    parameter int V_BP       = display_pkg::V_BP,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] st_pixel_data,
    input  logic        st_pixel_valid,
    output logic        st_pixel_ready,
    output logic        next_frame,
    output logic [23:0] lcd_rgb,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic        lcd_de,
    output logic        underflow,
    input  logic        underflow_clear
);

    import display_pkg::*;

    localparam int CW = 16;
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] C_H_ACTIVE = CW'(H_ACTIVE);
    localparam logic [CW-1:0] C_H_LAST   = CW'(HT - 1);
    localparam logic [CW-1:0] C_HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] C_HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] C_V_ACTIVE = CW'(V_ACTIVE);
    localparam logic [CW-1:0] C_V_LAST   = CW'(VT - 1);
    localparam logic [CW-1:0] C_VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] C_VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic          r_run;
    logic          w_active;
    logic          w_hsync_n;
    logic          w_vsync_n;
    logic          w_next_frame;
    logic          w_fifo_wr;
    logic          w_fifo_rd;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    rgb888_t       w_fifo_head;

    assign w_active     = (r_h < C_H_ACTIVE) && (r_v < C_V_ACTIVE);
    assign w_hsync_n    = !((r_h >= C_HS_START) && (r_h < C_HS_END));
    assign w_vsync_n    = !((r_v >= C_VS_START) && (r_v < C_VS_END));
    assign w_next_frame = (r_h == '0) && (r_v == C_VS_START);

    // Ready depends only on registered state; r_run keeps it low until the first clock after reset.
    assign st_pixel_ready = r_run && !w_fifo_full && !w_next_frame;
    assign next_frame     = w_next_frame;
    assign w_fifo_wr      = st_pixel_valid && st_pixel_ready;
    assign w_fifo_rd      = w_active && !w_fifo_empty;

    pixel_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_pixel_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .flush   (w_next_frame),
        .wr_en   (w_fifo_wr),
        .wr_data (st_pixel_data),
        .rd_en   (w_fifo_rd),
        .rd_data (w_fifo_head),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full)
    );

    // Reset lands in the vertical front porch so the first next_frame precedes any active pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h <= '0;
            r_v <= C_V_ACTIVE;
        end else if (r_h == C_H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == C_V_LAST) ? '0 : r_v + CW'(1);
        end else begin
            r_h <= r_h + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run     <= 1'b0;
            lcd_rgb   <= '0;
            lcd_hsync <= 1'b1;
            lcd_vsync <= 1'b1;
            lcd_de    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            r_run     <= 1'b1;
            lcd_de    <= w_active;
            lcd_hsync <= w_hsync_n;
            lcd_vsync <= w_vsync_n;
            lcd_rgb   <= w_fifo_rd ? w_fifo_head : '0;
            // An empty FIFO in an active slot loses that pixel; timing never stalls.
            if (w_active && w_fifo_empty) begin
                underflow <= 1'b1;
            end else if (underflow_clear) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_scanout.sv
// tb/tb_lcd_scanout.sv - scoreboard bench for lcd_scanout on a reduced panel geometry
module tb_lcd_scanout;

    localparam int HA = 16, HFP = 4, HS = 3, HBP = 5;
    localparam int VA = 6, VFP = 2, VS = 2, VBP = 3;
    localparam int DEPTH = 16;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    localparam int M_ORDER = 0, M_RAND = 1, M_IDLE = 2, M_STALE = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] st_pixel_data = '0;
    logic        st_pixel_valid = 1'b0;
    logic        underflow_clear = 1'b0;
    logic        st_pixel_ready;
    logic        next_frame;
    logic [23:0] lcd_rgb;
    logic        lcd_hsync;
    logic        lcd_vsync;
    logic        lcd_de;
    logic        underflow;

    always #5 clk = ~clk;

    lcd_scanout #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .st_pixel_data   (st_pixel_data),
        .st_pixel_valid  (st_pixel_valid),
        .st_pixel_ready  (st_pixel_ready),
        .next_frame      (next_frame),
        .lcd_rgb         (lcd_rgb),
        .lcd_hsync       (lcd_hsync),
        .lcd_vsync       (lcd_vsync),
        .lcd_de          (lcd_de),
        .underflow       (underflow),
        .underflow_clear (underflow_clear)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    endtask

    // Reference model: panel position derived from cycles since reset release.
    int          m_t, m_p, m_h, m_v, last_nf_t, bp_cnt;
    bit          m_running, m_act, m_nf, m_rdy, m_set, first_nf_seen, bp_armed;
    bit          e_de, e_hs, e_vs, e_uf;
    logic [23:0] mq[$];
    logic [23:0] exp_q[$];
    bit          order_mode = 1'b1;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_t = 0; m_running = 0; first_nf_seen = 0; bp_armed = 0; bp_cnt = 0;
            mq.delete(); exp_q.delete();
            e_de = 0; e_hs = 1; e_vs = 1; e_uf = 0;
        end else begin
            m_p = (VA * HT + m_t) % FRAME;
            m_h = m_p % HT;
            m_v = m_p / HT;
            m_act = (m_h < HA) && (m_v < VA);
            m_nf = (m_h == 0) && (m_v == VA + VFP);
            m_rdy = m_running && (mq.size() < DEPTH) && !m_nf;
            m_set = 0;
            check("lcd_de", lcd_de, e_de);
            check("lcd_hsync", lcd_hsync, e_hs);
            check("lcd_vsync", lcd_vsync, e_vs);
            check("underflow", underflow, e_uf);
            check("next_frame", next_frame, m_nf);
            check("st_pixel_ready", st_pixel_ready, m_rdy);
            if (bp_armed && !st_pixel_valid) bp_armed = 0;
            if (m_act && m_h == 0 && m_v == 0 && bp_armed) begin
                check("prefill_transfers", bp_cnt, DEPTH);
                bp_armed = 0;
            end
            if (m_act) begin
                if (mq.size() > 0) exp_q.push_back(mq.pop_front());
                else begin
                    exp_q.push_back(24'h0);
                    m_set = 1;
                end
            end
            if (m_nf) begin
                if (!first_nf_seen) check("first_next_frame_delay", m_t, VFP * HT);
                else check("frame_period", m_t - last_nf_t, FRAME);
                first_nf_seen = 1;
                last_nf_t = m_t;
                mq.delete();
                bp_cnt = 0;
                bp_armed = 1;
            end
            if (st_pixel_valid && m_rdy) begin
                mq.push_back(st_pixel_data);
                bp_cnt++;
            end
            e_de = m_act;
            e_hs = !((m_h >= HA + HFP) && (m_h < HA + HFP + HS));
            e_vs = !((m_v >= VA + VFP) && (m_v < VA + VFP + VS));
            e_uf = m_set ? 1'b1 : (underflow_clear ? 1'b0 : e_uf);
            m_running = 1;
            m_t++;
        end
    end

    // Monitor: every displayed pixel is popped from the scoreboard and compared.
    int          k, de_cnt;
    bit          mon_full;
    logic [23:0] e_pix;

    always @(negedge clk) begin
        if (!reset_n) begin
            k = 0; de_cnt = 0; mon_full = 0;
        end else begin
            if (next_frame) begin
                if (mon_full) check("de_per_frame", de_cnt, HA * VA);
                mon_full = 1; de_cnt = 0; k = 0;
            end
            if (lcd_de) begin
                de_cnt++;
                if (exp_q.size() == 0) check("scoreboard_has_entry", 0, 1);
                else begin
                    e_pix = exp_q.pop_front();
                    check("lcd_rgb", lcd_rgb, e_pix);
                    if (order_mode) check("pixel_order", lcd_rgb, k);
                end
                k++;
            end else begin
                check("lcd_rgb_blank", lcd_rgb, 0);
            end
        end
    end

    int pix = 0;
    int valid_pct = 60;
    int clr_pct = 0;
    bit clr_hold = 0;

    task automatic step(input int mode, output bit nf, output bit xfer);
        @(negedge clk);
        xfer = st_pixel_valid && st_pixel_ready;
        nf = next_frame;
        @(posedge clk);
        #1;
        if (nf) pix = 0;
        else if (xfer) pix++;
        case (mode)
            M_ORDER: begin st_pixel_valid = 1'b1; st_pixel_data = 24'(pix); end
            M_RAND:  begin st_pixel_valid = ($urandom_range(99) < valid_pct); st_pixel_data = 24'($urandom); end
            M_IDLE:  st_pixel_valid = 1'b0;
            default: begin st_pixel_valid = (pix < 7); st_pixel_data = 24'hABC000 | 24'(pix); end
        endcase
        underflow_clear = clr_hold || ((mode == M_RAND) && ($urandom_range(99) < clr_pct));
    endtask

    task automatic run(input int mode, input int n);
        bit nf, xf;
        for (int i = 0; i < n; i++) step(mode, nf, xf);
    endtask

    task automatic run_until_nf(input int mode);
        bit nf, xf;
        int n;
        n = 0;
        do begin
            step(mode, nf, xf);
            n++;
        end while (!nf && n < FRAME + HT);
        if (!nf) check("next_frame_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_lcd_rgb", lcd_rgb, 0);
        check("rst_lcd_hsync", lcd_hsync, 1);
        check("rst_lcd_vsync", lcd_vsync, 1);
        check("rst_lcd_de", lcd_de, 0);
        check("rst_next_frame", next_frame, 0);
        check("rst_ready", st_pixel_ready, 0);
        check("rst_underflow", underflow, 0);
    endtask

    initial begin
        bit nf, xf;
        int n;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        st_pixel_valid = 1'b1;
        st_pixel_data = 24'h0;
        reset_n = 1'b1;

        run(M_ORDER, 3 * FRAME);

        order_mode = 0;
        valid_pct = 60; clr_pct = 5;
        run(M_RAND, 3 * FRAME);

        valid_pct = 25; clr_pct = 0; clr_hold = 1;
        run(M_RAND, FRAME);
        clr_hold = 0;
        run(M_RAND, FRAME);
        clr_pct = 3;
        run(M_RAND, FRAME / 2);

        n = 0;
        do begin
            step(M_RAND, nf, xf);
            n++;
        end while (!(lcd_de && underflow) && n < 2 * FRAME);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        run_until_nf(M_IDLE);
        run_until_nf(M_IDLE);
        run(M_IDLE, FRAME - VFP * HT + 2);
        run(M_STALE, 20);
        run_until_nf(M_IDLE);
        order_mode = 1;
        run(M_ORDER, 2 * FRAME + 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
